// File: rtl/sms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sms_pkg
// Brief    : Shared types and constants for the serial S-box layer: word
//            width, FSM encoding, default word count and a reference x^17
//            table over GF(2^6) with field polynomial x^6 + x + 1.
// Revision : 1.0 - initial release
// ============================================================================
package sms_pkg;

   localparam int WORD_W         = 6;
   localparam int NWORDS_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sms_state_e;

   // S(x) = x^17 in GF(2^6) mod x^6 + x + 1, indexed by x.
   localparam logic [WORD_W-1:0] SBOX_TABLE [64] = '{
      6'h00, 6'h01, 6'h26, 6'h36, 6'h24, 6'h28, 6'h1F, 6'h02,
      6'h2B, 6'h2F, 6'h09, 6'h1C, 6'h30, 6'h39, 6'h0F, 6'h17,
      6'h20, 6'h33, 6'h3E, 6'h3C, 6'h1A, 6'h04, 6'h19, 6'h16,
      6'h0E, 6'h18, 6'h14, 6'h13, 6'h0B, 6'h10, 6'h0C, 6'h06,
      6'h35, 6'h32, 6'h27, 6'h31, 6'h23, 6'h29, 6'h2C, 6'h37,
      6'h08, 6'h0A, 6'h1E, 6'h0D, 6'h21, 6'h2E, 6'h2A, 6'h34,
      6'h2D, 6'h38, 6'h07, 6'h03, 6'h25, 6'h3D, 6'h12, 6'h1B,
      6'h15, 6'h05, 6'h3B, 6'h3A, 6'h22, 6'h3F, 6'h11, 6'h1D
   };

   function automatic logic [WORD_W-1:0] sbox_ref(input logic [WORD_W-1:0] x);
      return SBOX_TABLE[x];
   endfunction

endpackage
`default_nettype wire

// File: rtl/sms_sbox6.sv
`default_nettype none
// ============================================================================
// Module   : sms_sbox6
// Brief    : Combinational x^17 S-box over GF(2^6) (poly x^6 + x + 1).
//            The input is mapped into GF((2^3)^2) with GF(8) = GF(2)[w]/
//            (w^3 + w + 1) and extension y^2 + y + 1. There x^17 = N(x) *
//            conj(x), where N(x) = x^9 = a^2 + ab + b^2 for x = a*y + b and
//            conj(x) = x^8 = a*y + (a + b). The result is mapped back.
// Revision : 1.0 - initial release
// ============================================================================
module sms_sbox6
   import sms_pkg::*;
(
   input  logic [WORD_W-1:0] i_data,
   output logic [WORD_W-1:0] o_data
);

   // GF(8) product reduced with w^3 = w + 1, w^4 = w^2 + w.
   function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
      logic [4:0] p;
      p[0] = a[0] & b[0];
      p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
      p[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
      p[3] = (a[2] & b[1]) ^ (a[1] & b[2]);
      p[4] = a[2] & b[2];
      return {p[2] ^ p[4], p[1] ^ p[3] ^ p[4], p[0] ^ p[3]};
   endfunction

   // GF(8) square: linear, a0 + a1*w^2 + a2*(w^2 + w).
   function automatic logic [2:0] gf8_sq(input logic [2:0] a);
      return {a[1] ^ a[2], a[2], a[0]};
   endfunction

   logic [2:0] w_a;
   logic [2:0] w_b;
   logic [2:0] w_n;
   logic [2:0] w_ao;
   logic [2:0] w_bo;

   // Standard basis -> tower basis (x = a*y + b); y maps to alpha^21 and
   // w maps to alpha^54.
   assign w_a = {i_data[3] ^ i_data[4] ^ i_data[1] ^ i_data[5],
                 i_data[2] ^ i_data[1] ^ i_data[5],
                 i_data[5]};
   assign w_b = {i_data[4] ^ i_data[1],
                 i_data[1] ^ i_data[5],
                 i_data[0] ^ i_data[1] ^ i_data[2] ^ i_data[4] ^ i_data[5]};

   // Norm into GF(8), then multiply by the conjugate.
   assign w_n  = gf8_sq(w_a) ^ gf8_mul(w_a, w_b) ^ gf8_sq(w_b);
   assign w_ao = gf8_mul(w_n, w_a);
   assign w_bo = gf8_mul(w_n, w_a ^ w_b);

   // Tower basis -> standard basis.
   assign o_data = {w_ao[0],
                    w_bo[1] ^ w_bo[2] ^ w_ao[0],
                    w_bo[2] ^ w_ao[0] ^ w_ao[2],
                    w_bo[1] ^ w_ao[1],
                    w_bo[1] ^ w_ao[0],
                    w_bo[0] ^ w_bo[1] ^ w_bo[2] ^ w_ao[0] ^ w_ao[1]};

endmodule
`default_nettype wire

// File: rtl/sms_sbox_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : sms_sbox_layer_serial
// Brief    : Serial substitution layer. One shared S-box processes the low
//            word of a rotating shift register each cycle; after NWORDS
//            shifts every word is substituted and back in place. Valid/ready
//            on both sides, with a zero-bubble handoff from DONE into RUN.
// Revision : 1.0 - initial release
// ============================================================================
module sms_sbox_layer_serial
   import sms_pkg::*;
#(
   parameter int NWORDS = NWORDS_DEFAULT,
   parameter int CNT_W  = $clog2(NWORDS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD_W*NWORDS-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD_W*NWORDS-1:0] out_data,
   output logic                     busy
);

   localparam int               ST_W     = WORD_W * NWORDS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

   sms_state_e        state_q, state_d;
   logic [ST_W-1:0]   st_q, st_d;
   logic [ST_W-1:0]   res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] w_sbox_out;
   logic [ST_W-1:0]   w_shift;

   sms_sbox6 u_sbox (
      .i_data (st_q[WORD_W-1:0]),
      .o_data (w_sbox_out)
   );

   // Substituted low word enters at the top; the rest rotate down one word.
   assign w_shift  = {w_sbox_out, st_q[ST_W-1:WORD_W]};
   // Result lives in its own register so out_data keeps the last result
   // while the next state is being shifted.
   assign out_data = res_q;

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_d    = in_data;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            st_d  = w_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               res_d   = w_shift;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  st_d    = in_data;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, shift register, result and counter; reset discards any work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         st_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   // The word counter must stay within 0..NWORDS-1.
   cnt_range_a: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, cnt_q} < (CNT_W + 1)'(NWORDS)));

endmodule
`default_nettype wire

// File: tb/tb_sms_sbox_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sms_sbox_layer_serial
// Brief    : Directed self-checking bench for sms_sbox_layer_serial (8 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sms_sbox_layer_serial;
   import sms_pkg::*;

   localparam int NW = 8;
   localparam int W  = WORD_W * NW;

   logic         clk       = 1'b0;
   logic         rst       = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] in_data   = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [W-1:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;

   sms_sbox_layer_serial #(.NWORDS(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NW; i++) r[WORD_W*i +: WORD_W] = sbox_ref(d[WORD_W*i +: WORD_W]);
      return r;
   endfunction

   // Present one state from IDLE, wait for the result, then take it.
   task automatic run_one(input logic [W-1:0] din, output logic [W-1:0] dout, output int lat);
      in_data  = din;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      dout = out_data;
      if (out_ready) step();
   endtask

   initial begin
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic [W-1:0] a_vec, b_vec, d_vec, e_vec;
      logic [W-1:0] c_vec [3];
      logic [W-1:0] word_order_exp;
      bit           seen [64];
      int           lat, distinct, idx, got, cyc, last_cyc, idle_bad;
      bit           acc, started;

      // ---------------- reset state
      step();
      check_eq("rst_out_valid", W'(out_valid), W'(0));
      check_eq("rst_in_ready",  W'(in_ready),  W'(1));
      check_eq("rst_busy",      W'(busy),      W'(0));
      check_eq("rst_out_data",  out_data,      '0);
      rst = 1'b0;
      step();

      // ---------------- zero / one fixed points
      run_one('0, dout, lat);
      check_eq("zero_data", dout, '0);
      check_eq("zero_lat",  W'(lat), W'(NW));
      din = {NW{6'h01}};
      run_one(din, dout, lat);
      check_eq("one_data", dout, {NW{6'h01}});
      check_eq("one_lat",  W'(lat), W'(NW));

      // ---------------- word ordering: word i = i
      for (int i = 0; i < NW; i++) din[WORD_W*i +: WORD_W] = 6'(i);
      word_order_exp = {6'h02, 6'h1F, 6'h28, 6'h24, 6'h36, 6'h26, 6'h01, 6'h00};
      run_one(din, dout, lat);
      check_eq("word_order", dout, word_order_exp);

      // ---------------- exhaustive words 0..63
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      distinct = 0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NW; i++) din[WORD_W*i +: WORD_W] = 6'(8*k + i);
         run_one(din, dout, lat);
         check_eq("exhaustive", dout, model(din));
         for (int i = 0; i < NW; i++) begin
            if (!seen[dout[WORD_W*i +: WORD_W]]) distinct++;
            seen[dout[WORD_W*i +: WORD_W]] = 1'b1;
         end
      end
      check_eq("bijection", W'(distinct), W'(64));

      // ---------------- backpressure in DONE
      a_vec = 48'h1234_5678_9ABC;
      b_vec = 48'hFEDC_BA98_7654;
      out_ready = 1'b0;
      in_data   = a_vec;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      check_eq("bp_lat", W'(lat), W'(NW));
      in_data  = b_vec;
      in_valid = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         check_eq("bp_hold_valid", W'(out_valid), W'(1));
         check_eq("bp_hold_data",  out_data, model(a_vec));
         check_eq("bp_in_ready",   W'(in_ready), W'(0));
         step();
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", W'(in_ready), W'(1));
      step();
      in_valid = 1'b0;
      check_eq("bp_after_valid", W'(out_valid), W'(0));
      check_eq("bp_after_busy",  W'(busy),      W'(1));
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      check_eq("bp_new_lat",  W'(lat), W'(NW));
      check_eq("bp_new_data", out_data, model(b_vec));
      step();

      // ---------------- back-to-back with continuous out_ready
      c_vec[0] = 48'h0F0F_0F0F_0F0F;
      c_vec[1] = 48'hA5A5_5A5A_C3C3;
      c_vec[2] = 48'h7777_1111_EEEE;
      out_ready = 1'b1;
      in_data   = c_vec[0];
      in_valid  = 1'b1;
      #1;
      idx = 0; got = 0; cyc = 0; last_cyc = 0; idle_bad = 0; started = 1'b0;
      while (got < 3 && cyc < 100) begin
         acc = in_valid && in_ready;
         if (out_valid) begin
            check_eq("b2b_data", out_data, model(c_vec[got]));
            if (got > 0) check_eq("b2b_spacing", W'(cyc - last_cyc), W'(NW + 1));
            last_cyc = cyc;
            got++;
         end else if (started && !busy) begin
            idle_bad++;
         end
         step();
         cyc++;
         if (acc) begin
            idx++;
            started = 1'b1;
            if (idx < 3) in_data = c_vec[idx];
            else         in_valid = 1'b0;
         end
      end
      check_eq("b2b_count",   W'(got),      W'(3));
      check_eq("b2b_no_idle", W'(idle_bad), W'(0));

      // ---------------- reset in the middle of RUN
      d_vec = 48'h0123_4567_89AB;
      e_vec = 48'hCAFE_F00D_BEEF;
      in_data  = d_vec;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      #2 rst = 1'b1;
      #1;
      check_eq("midrst_out_valid", W'(out_valid), W'(0));
      check_eq("midrst_busy",      W'(busy),      W'(0));
      check_eq("midrst_in_ready",  W'(in_ready),  W'(1));
      check_eq("midrst_out_data",  out_data,      '0);
      rst = 1'b0;
      step();
      run_one(e_vec, dout, lat);
      check_eq("midrst_next_data", dout, model(e_vec));
      check_eq("midrst_next_lat",  W'(lat), W'(NW));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
